imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the byte-addressed instruction memory: accepts a byte stream (4-byte big-endian length header, then program bytes), writes each byte sequentially from address 0 through a byte write port, and holds the core in reset until the image is loaded. It sits between the host/UART byte source and the instruction memory write side. Byte order in memory equals stream order, so the first byte lands at address 0 and is the MSB of the first instruction word on the memory's 32-bit read port.

## Interface
- DATA_WIDTH, 8, width of one memory byte and one stream byte
- ADDR_WIDTH, 32, memory address width
- MEM_BYTES, 91, memory depth in bytes; lengths above this are rejected

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  re-arm pulse; restarts loading from DONE or ERR
- in_valid  in  1  stream byte valid
- in_data  in  DATA_WIDTH  stream byte
- in_ready  out  1  loader can accept a byte
- mem_we  out  1  byte write strobe, one cycle per byte
- mem_addr  out  ADDR_WIDTH  byte write address
- mem_wdata  out  DATA_WIDTH  byte write data
- cpu_rst  out  1  core reset, high until DONE
- done  out  1  image loaded successfully
- error  out  1  load aborted

## Operation
- States: LEN, DATA, CSUM (only with checksum compiled in), DONE, ERR.
- Reset: state LEN, byte counter 0, length 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, done 0, error 0.
- Transfer occurs when in_valid && in_ready; in_ready = 1 in LEN, DATA, CSUM, else 0.
- LEN: shift in 4 bytes MSB first. After the 4th byte: length > MEM_BYTES -> ERR; length == 0 -> CSUM if enabled else DONE; otherwise -> DATA.
- DATA: each transferred byte is written at address = count, count increments; after byte number length -> CSUM if enabled else DONE.
- DONE: cpu_rst 0, done 1; stream ignored (in_ready 0).
- ERR: cpu_rst 1, error 1; in_ready 0.
- start in DONE or ERR: -> LEN, count/length cleared, done/error/cpu_rst back to reset values. start in LEN/DATA/CSUM is ignored.
- Counter is ADDR_WIDTH wide; it never wraps because length ≤ MEM_BYTES.

## Timing
- mem_we, mem_addr, mem_wdata registered: asserted exactly one cycle after the accepting edge, for one cycle; back-to-back bytes give back-to-back writes.
- Sustained throughput: one byte per cycle; no bubbles inserted.
- done/cpu_rst update on the edge that accepts the final byte; the final mem_we pulse occurs in the same cycle done first reads 1.
- rst mid-load: abandons the image, returns to LEN; partially written memory is not cleared.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the payload, one extra byte is expected; it must equal XOR of all payload bytes (0x00 for empty payload). Match -> DONE; mismatch -> ERR (cpu_rst stays 1).
- Undefined: no CSUM state, no checksum byte; DATA exits directly to DONE.

## Structure
- Shared package: state encodings, header byte count (4), checksum byte count (1).
- Single module; the length shift register, counter, and XOR accumulator are a few lines each, so no sub-module is warranted.

## Test plan
- Header 00 00 00 04, payload 13 05 00 00 -> writes (0,13),(1,05),(2,00),(3,00); done=1, cpu_rst=0 on the last accept.
- Header 00 00 00 5C (92 > 91) -> ERR, error=1, zero mem_we pulses, in_ready=0.
- Length 0 (no checksum) -> DONE right after the 4th header byte, no writes.
- in_valid toggled every other cycle on 8-byte load -> 8 writes at addresses 0–7 in order, no duplicates.
- rst asserted after 2 payload bytes, then a fresh 4-byte load -> writes restart at address 0; done after the 4th byte.
- With IMEM_LOADER_CHECKSUM_EN: payload 01 02 04, checksum 07 -> DONE; checksum 06 -> ERR; start then a valid load -> DONE.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HdrBytes  = 4;
  localparam int unsigned CsumBytes = 1;

endpackage

// File: rtl/imem_loader.sv
// Boot-time byte-stream loader for the instruction memory; holds the core in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 91
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned LenWidth = HdrBytes * DATA_WIDTH;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                  accept;
  logic [LenWidth-1:0]   len_next;
  logic [ADDR_WIDTH-1:0] count_inc;

  assign in_ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept    = in_valid && in_ready;
  assign len_next  = {len_q[LenWidth-DATA_WIDTH-1:0], in_data};
  assign count_inc = count_q + ADDR_WIDTH'(1);

  // Status follows the state register so it changes on the edge accepting the final byte.
  assign done    = (state_q == StDone);
  assign error   = (state_q == StErr);
  assign cpu_rst = (state_q != StDone);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      StLen: begin
        if (accept) begin
          len_d   = len_next;
          count_d = count_inc;
          // The header reuses the byte counter, cleared again before payload addressing.
          if (count_q == ADDR_WIDTH'(HdrBytes - 1)) begin
            count_d = '0;
            if (len_next > LenWidth'(MEM_BYTES)) begin
              state_d = StErr;
            end else if (len_next == '0) begin
              state_d = StAfterData;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q;
          mem_wdata_d = in_data;
          count_d     = count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ in_data;
`endif
          if (count_inc == ADDR_WIDTH'(len_q)) begin
            state_d = StAfterData;
          end
        end
      end
      StCsum: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
`else
        state_d = StLen;
`endif
      end
      StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          count_d = '0;
          len_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      default: state_d = StLen;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLen;
      count_q   <= '0;
      len_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      len_q     <= len_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level image model.
module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] wa_q[$];
  logic [7:0]  wd_q[$];
  logic        wdone_q[$];

  imem_loader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(32),
    .MEM_BYTES (91)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Capture every write pulse together with the done flag seen in the same cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      wdone_q.push_back(done);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Image-level model: header gives the length, payload lands at addresses 0..len-1.
  function automatic void model(input byte_q_t s, output byte_q_t pay, output bit exp_done,
                                output bit exp_err);
    int unsigned len;
    logic [7:0]  x;
    pay = {};
    len = {s[0], s[1], s[2], s[3]};
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (len > 91) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      pay.push_back(s[4 + i]);
      x = x ^ s[4 + i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err  = (s[4 + len] != x);
    exp_done = !exp_err;
`else
    exp_done = 1'b1;
`endif
  endfunction

  function automatic byte_q_t make_stream(input int unsigned len, input byte_q_t pay,
                                          input bit bad_csum);
    byte_q_t     s;
    logic [7:0]  x;
    s = {};
    for (int k = 3; k >= 0; k--) s.push_back(8'(len >> (8 * k)));
    x = 8'h00;
    foreach (pay[i]) begin
      s.push_back(pay[i]);
      x = x ^ pay[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len <= 91) s.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
    if (bad_csum) x = 8'h00;
`endif
    return s;
  endfunction

  // gap: 0 = back-to-back, 1 = every other cycle, 2 = random idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int idle;
    idle = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
    repeat (idle) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic rearm(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, ":rearm_done"}, 32'(done), 32'd0);
    check_eq({name, ":rearm_err"}, 32'(error), 32'd0);
    check_eq({name, ":rearm_cpurst"}, 32'(cpu_rst), 32'd1);
    check_eq({name, ":rearm_rdy"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_load(input string name, input byte_q_t s, input int gap);
    byte_q_t pay;
    bit      ed, ee;
    wa_q.delete();
    wd_q.delete();
    wdone_q.delete();
    foreach (s[i]) send_byte(s[i], gap);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    model(s, pay, ed, ee);
    check_eq({name, ":nwr"}, 32'(wa_q.size()), 32'(pay.size()));
    for (int i = 0; i < pay.size() && i < wa_q.size(); i++) begin
      check_eq($sformatf("%s:addr%0d", name, i), wa_q[i], 32'(i));
      check_eq($sformatf("%s:data%0d", name, i), 32'(wd_q[i]), 32'(pay[i]));
    end
    check_eq({name, ":done"}, 32'(done), 32'(ed));
    check_eq({name, ":error"}, 32'(error), 32'(ee));
    check_eq({name, ":cpu_rst"}, 32'(cpu_rst), 32'(!ed));
    check_eq({name, ":in_ready"}, 32'(in_ready), 32'(!(ed || ee)));
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (ed && pay.size() > 0 && wdone_q.size() == pay.size()) begin
      check_eq({name, ":last_wr_done"}, 32'(wdone_q[pay.size() - 1]), 32'd1);
      if (pay.size() > 1) check_eq({name, ":prev_wr_done"}, 32'(wdone_q[pay.size() - 2]), 32'd0);
    end
`endif
    if (ed || ee) rearm(name);
  endtask

  initial begin
    byte_q_t     s, p;
    int unsigned len;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst:cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst:done", 32'(done), 32'd0);
    check_eq("rst:error", 32'(error), 32'd0);
    check_eq("rst:mem_we", 32'(mem_we), 32'd0);
    check_eq("rst:mem_addr", mem_addr, 32'd0);
    check_eq("rst:mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst:in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    p = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_load("basic4", make_stream(4, p, 1'b0), 0);

    p = {};
    s = make_stream(92, p, 1'b0);
    s.push_back(8'hAA);
    s.push_back(8'h55);
    run_load("toolong", s, 0);

    run_load("len0", make_stream(0, p, 1'b0), 0);

    p = {};
    for (int i = 0; i < 8; i++) p.push_back(8'($urandom));
    run_load("toggle8", make_stream(8, p, 1'b0), 1);

    p = {};
    for (int i = 0; i < 91; i++) p.push_back(8'($urandom));
    run_load("full91", make_stream(91, p, 1'b0), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    p = '{8'h01, 8'h02, 8'h04};
    run_load("csum_ok", make_stream(3, p, 1'b0), 0);
    run_load("csum_bad", make_stream(3, p, 1'b1), 0);
    run_load("csum_again", make_stream(3, p, 1'b0), 2);
`endif

    // Reset in the middle of a payload abandons the image.
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    s = make_stream(6, p, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst:in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst:cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("midrst:mem_we", 32'(mem_we), 32'd0);
    p = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_load("after_rst", make_stream(4, p, 1'b0), 0);

    for (int n = 0; n < 14; n++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(92, 300) : $urandom_range(0, 91);
      p = {};
      if (len <= 91) for (int i = 0; i < int'(len); i++) p.push_back(8'($urandom));
      s = make_stream(len, p, ($urandom_range(0, 3) == 0));
      if (len > 91) s.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", n), s, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1);
  end

endmodule
